// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I opcodes, immediate formats and NOP shared by encoder blocks
package rv_isa_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_R,
    FMT_NONE
  } imm_fmt_t;

  function automatic imm_fmt_t fmt_of(input logic [6:0] opcode);
    imm_fmt_t f;
    case (opcode)
      OP_IMM, LOAD, JALR: f = FMT_I;
      STORE:              f = FMT_S;
      BRANCH:             f = FMT_B;
      JAL:                f = FMT_J;
      OP:                 f = FMT_R;
      default:            f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - combinational format select, immediate range check and RV32I packing
module imm_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  imm_fmt_t   fmt;
  logic       range_ok;
  logic [31:0] word;

  // An immediate fits when every bit above its sign bit copies the sign bit.
  always_comb begin
    fmt      = fmt_of(opcode);
    range_ok = 1'b0;
    word     = NOP;
    case (fmt)
      FMT_I: begin
        range_ok = (&imm[31:11]) | ~(|imm[31:11]);
        word     = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        range_ok = (&imm[31:11]) | ~(|imm[31:11]);
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        range_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_J: begin
        range_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_R: begin
        range_ok = 1'b1;
        word     = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        range_ok = 1'b0;
        word     = NOP;
      end
    endcase
    err   = ~range_ok;
    instr = range_ok ? word : NOP;
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - registered RV32I instruction packer with handshake and ok/err counters
module imm_encoder
  import rv_isa_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;

  imm_pack u_pack (
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register holds while stalled since accept is low whenever out_ready is low and data is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= pack_instr;
      out_err   <= pack_err;
      if (pack_err) err_cnt <= err_cnt + CNT_W'(1);
      else          ok_cnt  <= ok_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder against a behavioural model
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] ok_cnt, err_cnt;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    logic [6:0]  op;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_ok, m_err;
  bit          m_fresh;

  imm_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // Returns {err, word}; ranges expressed as signed integer bounds.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    longint v;
    logic [31:0] w;
    bit ok;
    v  = longint'($signed(imm));
    w  = 32'(op);
    ok = 1'b1;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        ok = (v >= -2048) && (v <= 2047);
        w |= ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
      end
      7'b0100011: begin
        ok = (v >= -2048) && (v <= 2047);
        w |= (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
           | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
      end
      7'b1100011: begin
        ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
        w |= (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
           | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
           | (((imm >> 11) & 32'h1) << 7);
      end
      7'b1101111: begin
        ok = (v >= -1048576) && (v <= 1048575) && (v % 2 == 0);
        w |= (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
           | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7);
      end
      7'b0110011: begin
        w |= (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h0000_0013;
    return {!ok, w};
  endfunction

  function automatic logic [31:0] decode_imm(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      7'b0100011: r = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b1101111: r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:    r = {{20{i[31]}}, i[31:20]};
    endcase
    return r;
  endfunction

  function automatic bit has_imm(input logic [6:0] op);
    return op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 ||
           op == 7'b0100011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  // Model: a FIFO of expected words, updated on each rising edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ok    = '0;
      m_err   = '0;
      m_fresh = 1'b1;
    end else begin
      bit rdy;
      logic [32:0] r;
      exp_t e;
      rdy = (q.size() == 0) || out_ready;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        r       = model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        e.instr = r[31:0];
        e.err   = r[32];
        e.imm   = in_imm;
        e.op    = in_opcode;
        q.push_back(e);
        if (r[32]) m_err++;
        else       m_ok++;
        m_fresh = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst === 1'b0 || rst === 1'b1) begin
      chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_err", 32'(out_err), 32'(q[0].err));
        if (!q[0].err && has_imm(q[0].op))
          chk("roundtrip", decode_imm(out_instr), q[0].imm);
      end else if (m_fresh) begin
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_err", 32'(out_err), 32'h0);
      end
      chk("ok_cnt", 32'(ok_cnt), 32'(m_ok));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // Enters and leaves 1 time unit after a rising edge.
  task automatic send_chk(input string name, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_instr, input logic exp_err);
    set_req(op, rd, rs1, rs2, f3, f7, imm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_instr"}, out_instr, exp_instr);
    chk({name, "_err"}, 32'(out_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    repeat (10) @(posedge clk);
    #1;

    send_chk("addi", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    chk("addi_ok_cnt", 32'(ok_cnt), 32'd1);
    send_chk("beq_m4", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    send_chk("beq_odd", 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0000_0013, 1'b1);
    chk("beq_err_cnt", 32'(err_cnt), 32'd1);
    send_chk("jal", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    send_chk("sw_2048", 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
    send_chk("lui", 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 32'h0000_0013, 1'b1);
    send_chk("add", 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h1234_5678, 32'h0020_81B3, 1'b0);
    chk("dir_ok_cnt", 32'(ok_cnt), 32'd4);
    chk("dir_err_cnt", 32'(err_cnt), 32'd3);

    // Backpressure: A accepted, B held three cycles, then B and C back to back.
    out_ready = 1'b0;
    set_req(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(posedge clk); #1;
    set_req(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_instr", out_instr, 32'h0050_0113);
      chk("stall_ready", 32'(in_ready), 32'h0);
      chk("stall_ok_cnt", 32'(ok_cnt), 32'd5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    set_req(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    @(negedge clk);
    chk("b2b_b", out_instr, 32'h0060_0193);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c", out_instr, 32'h0070_0213);
    chk("b2b_ok_cnt", 32'(ok_cnt), 32'd7);
    @(posedge clk); #1;

    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [7];
      logic [6:0] op;
      int s;
      ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b1100111; ops[3] = 7'b0100011;
      ops[4] = 7'b1100011; ops[5] = 7'b1101111; ops[6] = 7'b0110011;
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 15) == 0) op = 7'($urandom);
      case (op)
        7'b1100011: s = (int'($urandom) >>> 19) & ~1;
        7'b1101111: s = (int'($urandom) >>> 11) & ~1;
        default:    s = int'($urandom) >>> 20;
      endcase
      if ($urandom_range(0, 7) == 0) s = int'($urandom);
      else if ($urandom_range(0, 7) == 0) s = s | 1;
      set_req(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'(s));
      in_valid  = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (i == 200) rst = 1'b1;
      @(posedge clk); #1;
      if (i == 200) begin
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_instr", out_instr, 32'h0);
        chk("midrst_ok_cnt", 32'(ok_cnt), 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
